// File: rtl/spu_pkg.sv
// Shared types and constants for the SPU dual-issue stage.
package spu_pkg;

    localparam int NREG    = 128;
    localparam int REG_AW  = 7;
    localparam int LAT_W   = 4;
    localparam int ID_W    = 7;
    localparam int UNIT_W  = 3;
    localparam int INSTR_W = 32;

    localparam logic [ID_W-1:0] NOP_ID = 7'd0;
    localparam logic PIPE_EVEN = 1'b0;
    localparam logic PIPE_ODD  = 1'b1;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ID_W-1:0]    id;
        logic               pipe;
        logic [UNIT_W-1:0]  unit;
        logic [LAT_W-1:0]   lat;
        logic               wr;
        logic [REG_AW-1:0]  dst;
        logic [REG_AW-1:0]  ra;
        logic [REG_AW-1:0]  rb;
        logic [REG_AW-1:0]  rc;
        logic [2:0]         srcs;
    } slot_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ID_W-1:0]    id;
        logic [REG_AW-1:0]  dst;
        logic [UNIT_W-1:0]  unit;
        logic [LAT_W-1:0]   lat;
        logic               wr;
        logic [REG_AW-1:0]  ra;
        logic [REG_AW-1:0]  rb;
        logic [REG_AW-1:0]  rc;
    } port_t;

    function automatic port_t nop_port();
        port_t p;
        p    = '0;
        p.id = NOP_ID;
        return p;
    endfunction

    function automatic port_t to_port(input slot_t s);
        port_t p;
        p.instr = s.instr;
        p.id    = s.id;
        p.dst   = s.dst;
        p.unit  = s.unit;
        p.lat   = s.lat;
        p.wr    = s.wr;
        p.ra    = s.ra;
        p.rb    = s.rb;
        p.rc    = s.rc;
        return p;
    endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Per-register latency counters: decrement each edge, reloaded by issuing writers.
module issue_scoreboard
    import spu_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic [5:0][REG_AW-1:0]       i_src,
    output logic [5:0]                   o_src_rdy,
    input  logic [1:0][REG_AW-1:0]       i_dst,
    output logic [1:0][LAT_W-1:0]        o_dst_lat,
    input  logic [1:0]                   i_ld,
    input  logic [1:0][LAT_W-1:0]        i_ld_lat
);

    logic [LAT_W-1:0] r_sb [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) r_sb[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                // slot0 load has priority; equal dsts never co-issue
                if (i_ld[0] && i_dst[0] == REG_AW'(i))
                    r_sb[i] <= i_ld_lat[0];
                else if (i_ld[1] && i_dst[1] == REG_AW'(i))
                    r_sb[i] <= i_ld_lat[1];
                else if (r_sb[i] != '0)
                    r_sb[i] <= r_sb[i] - 1'b1;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 6; k++) o_src_rdy[k] = (r_sb[i_src[k]] == '0);
        for (int k = 0; k < 2; k++) o_dst_lat[k] = r_sb[i_dst[k]];
    end

endmodule

// File: rtl/dual_issue_ctrl.sv
// Dual-issue stage: buffers one decoded pair, checks hazards, routes to even/odd ports.
module dual_issue_ctrl
    import spu_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                s0_valid,
    input  logic [INSTR_W-1:0]  s0_instr,
    input  logic [ID_W-1:0]     s0_id,
    input  logic                s0_pipe,
    input  logic [UNIT_W-1:0]   s0_unit,
    input  logic [LAT_W-1:0]    s0_lat,
    input  logic                s0_wr,
    input  logic [REG_AW-1:0]   s0_dst,
    input  logic [REG_AW-1:0]   s0_ra,
    input  logic [REG_AW-1:0]   s0_rb,
    input  logic [REG_AW-1:0]   s0_rc,
    input  logic [2:0]          s0_use,
    input  logic                s1_valid,
    input  logic [INSTR_W-1:0]  s1_instr,
    input  logic [ID_W-1:0]     s1_id,
    input  logic                s1_pipe,
    input  logic [UNIT_W-1:0]   s1_unit,
    input  logic [LAT_W-1:0]    s1_lat,
    input  logic                s1_wr,
    input  logic [REG_AW-1:0]   s1_dst,
    input  logic [REG_AW-1:0]   s1_ra,
    input  logic [REG_AW-1:0]   s1_rb,
    input  logic [REG_AW-1:0]   s1_rc,
    input  logic [2:0]          s1_use,
    input  logic                flush,
    output logic [INSTR_W-1:0]  full_instr_even,
    output logic [ID_W-1:0]     instr_id_even,
    output logic [REG_AW-1:0]   reg_dst_even,
    output logic [UNIT_W-1:0]   unit_id_even,
    output logic [LAT_W-1:0]    latency_even,
    output logic                reg_wr_even,
    output logic [REG_AW-1:0]   ra_addr_even,
    output logic [REG_AW-1:0]   rb_addr_even,
    output logic [REG_AW-1:0]   rc_addr_even,
    output logic [INSTR_W-1:0]  full_instr_odd,
    output logic [ID_W-1:0]     instr_id_odd,
    output logic [REG_AW-1:0]   reg_dst_odd,
    output logic [UNIT_W-1:0]   unit_id_odd,
    output logic [LAT_W-1:0]    latency_odd,
    output logic                reg_wr_odd,
    output logic [REG_AW-1:0]   ra_addr_odd,
    output logic [REG_AW-1:0]   rb_addr_odd,
    output logic [REG_AW-1:0]   rc_addr_odd,
    output logic [31:0]         stall_cnt
);

    slot_t r_s0, r_s1, w_in0, w_in1;
    logic  r_p0, r_p1;
    port_t r_ev, r_od, w_ev, w_od;
    logic [31:0] r_stall;

    logic [5:0]            w_rdy;
    logic [1:0][LAT_W-1:0] w_dlat;
    logic w_ok0, w_ok1, w_raw01, w_pair_ok;
    logic w_iss0, w_iss1, w_acc, w_empty;

    assign w_in0 = '{s0_instr, s0_id, s0_pipe, s0_unit, s0_lat, s0_wr,
                     s0_dst, s0_ra, s0_rb, s0_rc, s0_use};
    assign w_in1 = '{s1_instr, s1_id, s1_pipe, s1_unit, s1_lat, s1_wr,
                     s1_dst, s1_ra, s1_rb, s1_rc, s1_use};

    issue_scoreboard u_sb (
        .clk       (clk),
        .rst       (rst),
        .i_src     ({r_s1.rc, r_s1.rb, r_s1.ra, r_s0.rc, r_s0.rb, r_s0.ra}),
        .o_src_rdy (w_rdy),
        .i_dst     ({r_s1.dst, r_s0.dst}),
        .o_dst_lat (w_dlat),
        .i_ld      ({w_iss1 && r_s1.wr, w_iss0 && r_s0.wr}),
        .i_ld_lat  ({r_s1.lat, r_s0.lat})
    );

    assign w_ok0 = &(~r_s0.srcs | {w_rdy[0], w_rdy[1], w_rdy[2]})
                   && (!r_s0.wr || w_dlat[0] <= r_s0.lat);
    assign w_ok1 = &(~r_s1.srcs | {w_rdy[3], w_rdy[4], w_rdy[5]})
                   && (!r_s1.wr || w_dlat[1] <= r_s1.lat);

    assign w_raw01 = r_s0.wr && ((r_s1.srcs[2] && r_s1.ra == r_s0.dst)
                              || (r_s1.srcs[1] && r_s1.rb == r_s0.dst)
                              || (r_s1.srcs[0] && r_s1.rc == r_s0.dst));
    assign w_pair_ok = (r_s1.pipe != r_s0.pipe) && !w_raw01
                       && !(r_s0.wr && r_s1.wr && r_s0.dst == r_s1.dst);

    // slot1 never overtakes slot0
    assign w_iss0  = r_p0 && w_ok0 && !flush;
    assign w_iss1  = r_p1 && w_ok1 && !flush
                     && (!r_p0 || (w_iss0 && w_pair_ok));
    assign w_empty = !r_p0 && !r_p1;

    assign in_ready = !flush && (!r_p0 || w_iss0) && (!r_p1 || w_iss1);
    assign w_acc    = in_valid && in_ready;

    always_comb begin
        w_ev = nop_port();
        w_od = nop_port();
        if (w_iss0) begin
            if (r_s0.pipe == PIPE_ODD) w_od = to_port(r_s0);
            else                       w_ev = to_port(r_s0);
        end
        if (w_iss1) begin
            if (r_s1.pipe == PIPE_ODD) w_od = to_port(r_s1);
            else                       w_ev = to_port(r_s1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s0    <= '0;
            r_s1    <= '0;
            r_p0    <= 1'b0;
            r_p1    <= 1'b0;
            r_ev    <= nop_port();
            r_od    <= nop_port();
            r_stall <= '0;
        end else begin
            r_ev <= w_ev;
            r_od <= w_od;
            if (flush) begin
                r_p0 <= 1'b0;
                r_p1 <= 1'b0;
            end else if (w_acc) begin
                r_s0 <= w_in0;
                r_s1 <= w_in1;
                r_p0 <= s0_valid;
                r_p1 <= s1_valid;
            end else begin
                r_p0 <= r_p0 && !w_iss0;
                r_p1 <= r_p1 && !w_iss1;
            end
            if (!w_empty && !flush && !w_iss0 && !w_iss1)
                r_stall <= r_stall + 32'd1;
        end
    end

    assign full_instr_even = r_ev.instr;
    assign instr_id_even   = r_ev.id;
    assign reg_dst_even    = r_ev.dst;
    assign unit_id_even    = r_ev.unit;
    assign latency_even    = r_ev.lat;
    assign reg_wr_even     = r_ev.wr;
    assign ra_addr_even    = r_ev.ra;
    assign rb_addr_even    = r_ev.rb;
    assign rc_addr_even    = r_ev.rc;
    assign full_instr_odd  = r_od.instr;
    assign instr_id_odd    = r_od.id;
    assign reg_dst_odd     = r_od.dst;
    assign unit_id_odd     = r_od.unit;
    assign latency_odd     = r_od.lat;
    assign reg_wr_odd      = r_od.wr;
    assign ra_addr_odd     = r_od.ra;
    assign rb_addr_odd     = r_od.rb;
    assign rc_addr_odd     = r_od.rc;
    assign stall_cnt       = r_stall;

endmodule

// File: tb/tb_dual_issue_ctrl.sv
// Directed bench for dual_issue_ctrl with an expected-issue queue.
module tb_dual_issue_ctrl;
    import spu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic in_valid, in_ready, flush;
    logic s0_valid, s0_pipe, s0_wr, s1_valid, s1_pipe, s1_wr;
    logic [31:0] s0_instr, s1_instr;
    logic [6:0] s0_id, s0_dst, s0_ra, s0_rb, s0_rc;
    logic [6:0] s1_id, s1_dst, s1_ra, s1_rb, s1_rc;
    logic [2:0] s0_unit, s0_use, s1_unit, s1_use;
    logic [3:0] s0_lat, s1_lat;
    logic [31:0] full_instr_even, full_instr_odd, stall_cnt;
    logic [6:0] instr_id_even, reg_dst_even, ra_addr_even, rb_addr_even, rc_addr_even;
    logic [6:0] instr_id_odd, reg_dst_odd, ra_addr_odd, rb_addr_odd, rc_addr_odd;
    logic [2:0] unit_id_even, unit_id_odd;
    logic [3:0] latency_even, latency_odd;
    logic reg_wr_even, reg_wr_odd;

    dual_issue_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .s0_valid(s0_valid), .s0_instr(s0_instr), .s0_id(s0_id), .s0_pipe(s0_pipe),
        .s0_unit(s0_unit), .s0_lat(s0_lat), .s0_wr(s0_wr), .s0_dst(s0_dst),
        .s0_ra(s0_ra), .s0_rb(s0_rb), .s0_rc(s0_rc), .s0_use(s0_use),
        .s1_valid(s1_valid), .s1_instr(s1_instr), .s1_id(s1_id), .s1_pipe(s1_pipe),
        .s1_unit(s1_unit), .s1_lat(s1_lat), .s1_wr(s1_wr), .s1_dst(s1_dst),
        .s1_ra(s1_ra), .s1_rb(s1_rb), .s1_rc(s1_rc), .s1_use(s1_use),
        .flush(flush),
        .full_instr_even(full_instr_even), .instr_id_even(instr_id_even),
        .reg_dst_even(reg_dst_even), .unit_id_even(unit_id_even),
        .latency_even(latency_even), .reg_wr_even(reg_wr_even),
        .ra_addr_even(ra_addr_even), .rb_addr_even(rb_addr_even),
        .rc_addr_even(rc_addr_even),
        .full_instr_odd(full_instr_odd), .instr_id_odd(instr_id_odd),
        .reg_dst_odd(reg_dst_odd), .unit_id_odd(unit_id_odd),
        .latency_odd(latency_odd), .reg_wr_odd(reg_wr_odd),
        .ra_addr_odd(ra_addr_odd), .rb_addr_odd(rb_addr_odd),
        .rc_addr_odd(rc_addr_odd),
        .stall_cnt(stall_cnt)
    );

    typedef struct packed {
        logic v; logic [31:0] instr; logic [6:0] id; logic pipe; logic [2:0] unit;
        logic [3:0] lat; logic wr; logic [6:0] dst, ra, rb, rc; logic [2:0] srcs;
    } sl_t;

    typedef struct { int cyc; logic [74:0] ev; logic [74:0] od; } exp_t;

    exp_t q[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int exp_stall = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic sl_t mk(input int id, input logic pipe, input logic wr,
                               input int dst, input int lat, input int ra,
                               input int rb, input int rc, input logic [2:0] srcs);
        sl_t s;
        s.v = 1'b1; s.instr = 32'hC0DE_0000 | id; s.id = 7'(id); s.pipe = pipe;
        s.unit = 3'(id); s.lat = 4'(lat); s.wr = wr; s.dst = 7'(dst);
        s.ra = 7'(ra); s.rb = 7'(rb); s.rc = 7'(rc); s.srcs = srcs;
        return s;
    endfunction

    function automatic logic [74:0] pk(input sl_t s);
        return s.v ? {s.id, s.dst, s.wr, s.lat, s.ra, s.rb, s.rc, s.unit, s.instr} : '0;
    endfunction

    function automatic logic [74:0] obs_ev();
        return {instr_id_even, reg_dst_even, reg_wr_even, latency_even, ra_addr_even,
                rb_addr_even, rc_addr_even, unit_id_even, full_instr_even};
    endfunction

    function automatic logic [74:0] obs_od();
        return {instr_id_odd, reg_dst_odd, reg_wr_odd, latency_odd, ra_addr_odd,
                rb_addr_odd, rc_addr_odd, unit_id_odd, full_instr_odd};
    endfunction

    task automatic push(input int c, input sl_t ev, input sl_t od);
        exp_t e;
        e.cyc = c; e.ev = pk(ev); e.od = pk(od);
        q.push_back(e);
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst) begin
            if (instr_id_even != NOP_ID || instr_id_odd != NOP_ID) begin
                if (q.size() == 0) begin
                    chk("unexpected_issue", {obs_ev(), obs_od()}, '0);
                end else begin
                    e = q.pop_front();
                    chk("issue_cycle", 160'(cyc), 160'(e.cyc));
                    chk("issue_even", obs_ev(), e.ev);
                    chk("issue_odd", obs_od(), e.od);
                end
            end else if (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                chk("missing_issue", {obs_ev(), obs_od()}, {e.ev, e.od});
            end
        end
    end

    task automatic drive(input sl_t a, input sl_t b);
        s0_valid = a.v; s0_instr = a.instr; s0_id = a.id; s0_pipe = a.pipe;
        s0_unit = a.unit; s0_lat = a.lat; s0_wr = a.wr; s0_dst = a.dst;
        s0_ra = a.ra; s0_rb = a.rb; s0_rc = a.rc; s0_use = a.srcs;
        s1_valid = b.v; s1_instr = b.instr; s1_id = b.id; s1_pipe = b.pipe;
        s1_unit = b.unit; s1_lat = b.lat; s1_wr = b.wr; s1_dst = b.dst;
        s1_ra = b.ra; s1_rb = b.rb; s1_rc = b.rc; s1_use = b.srcs;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // called at posedge+1; returns the index of the accepting edge
    task automatic send(input sl_t a, input sl_t b, output int acc);
        drive(a, b);
        in_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (in_ready) begin
                @(posedge clk);
                #1;
                acc = cyc;
                break;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (acc < 0) chk("send_timeout", 160'd0, 160'd1);
    endtask

    task automatic chk_nop(input string tag);
        chk({tag, "_even"}, obs_ev(), '0);
        chk({tag, "_odd"}, obs_od(), '0);
        chk({tag, "_stall"}, stall_cnt, 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        sl_t a, b, c, z;
        int acc, acc2;
        z = '0;
        in_valid = 1'b0;
        flush = 1'b0;
        drive(z, z);
        #1 rst = 1'b1;
        #1 chk_nop("reset");
        #10 rst = 1'b0;
        wait_cyc(1);
        chk("reset_ready", in_ready, 1);

        // independent pair dual-issues one cycle after accept
        a = mk(1, PIPE_EVEN, 1, 5, 2, 0, 0, 0, 3'b000);
        b = mk(2, PIPE_ODD, 1, 9, 1, 1, 2, 3, 3'b110);
        send(a, b, acc);
        chk("pair_ready", in_ready, 1);
        push(acc + 1, a, b);
        wait_cyc(8);
        chk("pair_stall", stall_cnt, 160'(exp_stall));

        // same pipe: split over two cycles on the even port
        a = mk(3, PIPE_EVEN, 0, 11, 1, 60, 61, 62, 3'b000);
        b = mk(4, PIPE_EVEN, 0, 12, 1, 63, 64, 65, 3'b000);
        send(a, b, acc);
        chk("samepipe_ready", in_ready, 0);
        push(acc + 1, a, z);
        push(acc + 2, b, z);
        wait_cyc(8);
        chk("samepipe_stall", stall_cnt, 160'(exp_stall));

        // RAW against scoreboard: lat=3 gives three stall cycles
        a = mk(5, PIPE_EVEN, 1, 5, 3, 0, 0, 0, 3'b000);
        b = mk(6, PIPE_ODD, 0, 13, 1, 5, 0, 0, 3'b100);
        send(a, z, acc);
        push(acc + 1, a, z);
        send(b, z, acc2);
        chk("raw_accept", 160'(acc2), 160'(acc + 1));
        push(acc2 + 4, z, b);
        exp_stall += 3;
        wait_cyc(10);
        chk("raw_stall", stall_cnt, 160'(exp_stall));

        // intra-pair RAW: slot1 waits lat cycles after slot0
        a = mk(7, PIPE_ODD, 1, 7, 2, 0, 0, 0, 3'b000);
        b = mk(8, PIPE_EVEN, 0, 14, 1, 7, 0, 0, 3'b100);
        send(a, b, acc);
        push(acc + 1, z, a);
        push(acc + 4, b, z);
        exp_stall += 2;
        wait_cyc(10);
        chk("intra_stall", stall_cnt, 160'(exp_stall));

        // flush with slot1 pending and a new pair offered
        a = mk(9, PIPE_EVEN, 1, 20, 4, 0, 0, 0, 3'b000);
        b = mk(10, PIPE_EVEN, 0, 21, 1, 0, 0, 0, 3'b000);
        send(a, b, acc);
        push(acc + 1, a, z);
        wait_cyc(1);
        drive(mk(11, PIPE_EVEN, 0, 1, 1, 0, 0, 0, 3'b000),
              mk(12, PIPE_ODD, 0, 2, 1, 0, 0, 0, 3'b000));
        in_valid = 1'b1;
        flush = 1'b1;
        #1 chk("flush_ready", in_ready, 0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        // sb[20] survives the flush: 4 at load, then 3, 2 at accept
        c = mk(13, PIPE_EVEN, 0, 22, 1, 20, 0, 0, 3'b100);
        send(c, z, acc);
        push(acc + 3, c, z);
        exp_stall += 2;
        wait_cyc(10);
        chk("flush_stall", stall_cnt, 160'(exp_stall));

        // lat=0 writer does not stall its dependent
        a = mk(14, PIPE_EVEN, 1, 30, 0, 0, 0, 0, 3'b000);
        b = mk(15, PIPE_ODD, 0, 31, 1, 0, 0, 30, 3'b001);
        send(a, z, acc);
        push(acc + 1, a, z);
        send(b, z, acc2);
        push(acc2 + 1, z, b);
        wait_cyc(6);
        chk("lat0_stall", stall_cnt, 160'(exp_stall));

        // WAW: second writer waits until sb[dst] <= its lat
        a = mk(16, PIPE_EVEN, 1, 50, 5, 0, 0, 0, 3'b000);
        b = mk(17, PIPE_ODD, 1, 50, 2, 0, 0, 0, 3'b000);
        send(a, z, acc);
        push(acc + 1, a, z);
        send(b, z, acc2);
        push(acc2 + 4, z, b);
        exp_stall += 3;
        wait_cyc(12);
        chk("waw_stall", stall_cnt, 160'(exp_stall));

        // async reset while a dependent is stalled
        a = mk(18, PIPE_EVEN, 1, 40, 9, 0, 0, 0, 3'b000);
        b = mk(19, PIPE_ODD, 0, 41, 1, 0, 40, 0, 3'b010);
        send(a, z, acc);
        send(b, z, acc2);
        chk("prerst_even_id", instr_id_even, 18);
        chk("prerst_stall", stall_cnt, 160'(exp_stall));
        #2 rst = 1'b1;
        #1 chk_nop("midrst");
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        #1 chk("midrst_ready", in_ready, 1);
        wait_cyc(12);
        chk("midrst_stall_after", stall_cnt, 0);
        c = mk(20, PIPE_ODD, 0, 42, 1, 40, 0, 0, 3'b100);
        send(c, z, acc);
        push(acc + 1, z, c);
        wait_cyc(4);

        chk("queue_empty", 160'(q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
